// File: rtl/win33_mul_sched_pkg.sv
// Shared mode codes, scheduler state encoding and multiplier handshake levels
// for the Winograd element-wise multiply scheduler.
package win33_mul_sched_pkg;

    localparam logic [1:0] MODE_8B  = 2'b00;
    localparam logic [1:0] MODE_16B = 2'b11;

    localparam logic FINISH   = 1'b1;
    localparam logic UNFINISH = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } sched_state_e;

    function automatic logic mode_legal(input logic [1:0] mode);
        return (mode == MODE_8B) || (mode == MODE_16B);
    endfunction

endpackage

// File: rtl/win_sched_timer.sv
// Timeout counter for the multiplier wait phase: cleared before each wait,
// counts while enabled and flags the final allowed cycle.
module win_sched_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] count;

    assign expire = (count == TW'(TIMEOUT - 1));

    // Count wait cycles; saturate at the expiry value so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= {TW{1'b0}};
        end else if (clear) begin
            count <= {TW{1'b0}};
        end else if (en && !expire) begin
            count <= count + TW'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/win33_mul_sched.sv
// Frame scheduler for win33_mul: fetches V/U tiles, issues one multiply per
// tile, waits for end_signal and forwards the product with index and last flag.
module win33_mul_sched
    import win33_mul_sched_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    cfg_num_tiles,
    input  logic [1:0]          cfg_mode,
    output logic                busy,
    output logic                frame_done,
    output logic                err,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [255:0]        in_v,
    input  logic [255:0]        in_u,
    output logic                mul_enable,
    output logic [1:0]          mul_bitwidth,
    output logic [255:0]        mul_v,
    output logic [255:0]        mul_u,
    input  logic                mul_done,
    input  logic [1023:0]       mul_m,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1023:0]       out_data,
    output logic [CNT_W-1:0]    out_idx,
    output logic                out_last
);

    sched_state_e     state;
    logic [CNT_W-1:0] tiles;
    logic [CNT_W-1:0] idx;
    logic             last_tile;
    logic             timer_clear;
    logic             timer_en;
    logic             timer_expire;

    assign last_tile   = (idx == tiles - CNT_W'(1));
    assign timer_clear = (state == ST_ISSUE);
    assign timer_en    = (state == ST_WAIT);

    win_sched_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .en     (timer_en),
        .expire (timer_expire)
    );

    // Scheduler FSM; every output is registered and set on the transition into its state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            tiles        <= {CNT_W{1'b0}};
            idx          <= {CNT_W{1'b0}};
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            err          <= 1'b0;
            in_ready     <= 1'b0;
            mul_enable   <= 1'b0;
            mul_bitwidth <= 2'b00;
            mul_v        <= 256'd0;
            mul_u        <= 256'd0;
            out_valid    <= 1'b0;
            out_data     <= 1024'd0;
            out_idx      <= {CNT_W{1'b0}};
            out_last     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            mul_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (!mode_legal(cfg_mode)) begin
                            err <= 1'b1;
                        end else if (cfg_num_tiles == {CNT_W{1'b0}}) begin
                            err        <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            err          <= 1'b0;
                            mul_bitwidth <= cfg_mode;
                            tiles        <= cfg_num_tiles;
                            idx          <= {CNT_W{1'b0}};
                            busy         <= 1'b1;
                            in_ready     <= 1'b1;
                            state        <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (in_valid) begin
                        mul_v      <= in_v;
                        mul_u      <= in_u;
                        in_ready   <= 1'b0;
                        mul_enable <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A late end_signal on the expiry cycle still wins over the abort.
                    if (mul_done == FINISH) begin
                        out_data  <= mul_m;
                        out_idx   <= idx;
                        out_last  <= last_tile;
                        out_valid <= 1'b1;
                        state     <= ST_DRAIN;
                    end else if (timer_expire) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (last_tile) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            idx      <= idx + CNT_W'(1);
                            in_ready <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
